shared_register_arbiter: RTL
============================

// Module: shared_register_arbiter
// PURPOSE
//   Round-robin arbiter that shares one WIDTH-bit parallel-load register between N_REQ requesters.
//   Each requester raises req[i] with its data; the winner's data is loaded into the register and acknowledged.
//   Sits between the lab's producer blocks and the shared parallel register; it is the only writer of that register.
// PARAMETERS
//   N_REQ  4  number of requesters (2..8)
//   WIDTH  4  data / register width in bits
// PORTS
//   clk         in   1             rising-edge clock
//   reset       in   1             synchronous, active-high reset
//   req         in   N_REQ         request, bit i = requester i
//   data_in     in   N_REQ*WIDTH   requester i data on bits [i*WIDTH +: WIDTH]
//   gnt         out  N_REQ         one-hot grant, registered
//   ack         out  N_REQ         one-cycle load acknowledge, registered
//   out         out  WIDTH         shared register contents
//   busy        out  1             high in any state except IDLE
//   load_count  out  8             number of completed loads, wraps
// BEHAVIOUR
//   Single clock, reset synchronous active-high; all outputs registered.
//   Reset: state=IDLE, gnt=0, ack=0, out=0, busy=0, load_count=0, ptr=0; applies mid-operation, aborting any transfer.
//   FSM: IDLE -> LOAD -> ACK -> RELEASE -> IDLE.
//   IDLE:
//     - if |req, winner = first set req bit scanning ptr, ptr+1, ..., wrapping mod N_REQ.
//     - gnt <= onehot(winner); busy <= 1; -> LOAD.
//     - if req==0, stay in IDLE with outputs unchanged.
//   LOAD:
//     - on the closing edge: out <= data_in[winner], load_count <= load_count+1 (255 wraps to 0), ack[winner] <= 1; -> ACK.
//     - the load is committed: it completes even if req[winner] drops during LOAD.
//   ACK: ack high exactly this one cycle; ack <= 0 on exit; -> RELEASE.
//   RELEASE:
//     - gnt held until req[winner]==0 is sampled.
//     - then gnt <= 0, busy <= 0, ptr <= winner+1 (N_REQ-1 wraps to 0); -> IDLE.
//   Latency: req sampled at edge k -> gnt valid after k; out, ack valid after k+1; earliest next grant after k+4.
//   Simultaneous requests: only the winner is served; losers keep req high and are served in rotation.
//   No requester is starved while holding req.
//   Requests arriving during a transfer are ignored until IDLE. out holds its value between loads.
// STRUCTURE
//   Shared header arb_defs.vh:
//     - state encodings S_IDLE=2'd0, S_LOAD=2'd1, S_ACK=2'd2, S_RELEASE=2'd3
//     - COUNT_W=8
//   Sub-module rr_priority_pick: combinational; inputs req and ptr; outputs winner index and valid.
//   Top holds the FSM, ptr, the winner index register, the out register and load_count.
// TESTING
//   1 Reset: assert reset 2 cycles -> gnt=0, ack=0, out=0000, busy=0, load_count=0.
//   2 Single request:
//       stimulus: req=0010, data1=0101 at edge k, released after ack.
//       response: gnt=0010 after k; out=0101 and ack=0010 after k+1; ack=0 after k+2; load_count=1.
//   3 Round-robin:
//       stimulus: req=1111 held, data=0001/0010/0100/1000; each requester drops req one cycle after its ack, then re-raises.
//       response: grant order 0,1,2,3,0 (ptr wraps); out sequence 0001,0010,0100,1000.
//   4 Early drop: req0 falls during LOAD -> out still loads data0, ack0 pulses, RELEASE exits next cycle.
//   5 Reset mid-transfer:
//       stimulus: reset asserted in ACK state.
//       response: all outputs zero next cycle; the next request from req=0100 is granted to requester 2 (ptr=0 scan).
//   6 Counter wrap: 256 single loads of 1111 -> load_count returns to 0, out=1111, no spurious ack.

Source files
------------

// File: rtl/shared_register_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shared_register_arbiter_pkg
// Brief   : FSM encoding, counter width and sizing helper for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package shared_register_arbiter_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // A single-requester build still needs a one-bit index.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_register_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_pick
// Brief   : Combinational round-robin pick: first set req bit from ptr upward.
// Revision: 1.0 - initial release
// ============================================================================
module rr_priority_pick
  import shared_register_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  // Offset i from ptr maps to requester j when ptr+i == j, modulo N_REQ.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid && req[j] &&
            ((int'(ptr) + i == j) || (int'(ptr) + i == j + N_REQ))) begin
          winner = PTR_W'(j);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_register_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : shared_register_arbiter
// Brief   : Round-robin arbiter; sole writer of one shared parallel register.
// Revision: 1.0 - initial release
// ============================================================================
module shared_register_arbiter
  import shared_register_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         out,
  output logic                     busy,
  output logic [COUNT_W-1:0]       load_count
);

  localparam int                 c_ptr_w    = ptr_width(N_REQ);
  localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   c_one      = N_REQ'(1);

  state_t               r_state;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [c_ptr_w-1:0]   r_winner;
  logic [N_REQ-1:0]     r_gnt;
  logic [N_REQ-1:0]     r_ack;
  logic [WIDTH-1:0]     r_out;
  logic                 r_busy;
  logic [COUNT_W-1:0]   r_count;

  logic [c_ptr_w-1:0]   w_pick;
  logic                 w_valid;
  logic [WIDTH-1:0]     w_sel_data;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (c_ptr_w)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_pick),
    .valid  (w_valid)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_winner == c_ptr_w'(i)) begin
        w_sel_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // The load in LOAD is unconditional: a requester dropping req mid-transfer
  // still gets its data written and acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_winner <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_out    <= '0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_winner <= w_pick;
            r_gnt    <= c_one << w_pick;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_out   <= w_sel_data;
          r_count <= r_count + 1'b1;
          r_ack   <= r_gnt;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_ack   <= '0;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!req[r_winner]) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= (r_winner == c_last_idx) ? '0 : r_winner + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign ack        = r_ack;
  assign out        = r_out;
  assign busy       = r_busy;
  assign load_count = r_count;

endmodule
`default_nettype wire
